led_shift_chain: RTL and testbench

- Parametrised cycle-level model of a cascade of N_CHIPS 74HC595-style serial-in/parallel-out LED driver stages. Successor to the fixed 4×8 panel controller.
- Adds a shift enable, a frame bit counter with a frame-complete pulse, a serial cascade output, and global PWM brightness dimming.
- Sits between the serial panel-driver logic and the LED panel outputs. It is used both as a behavioural panel model and as a synthesizable driver.

---
 rtl/led_pkg.sv | 21 ++
 rtl/led_pwm_gen.sv | 41 ++++
 rtl/led_shift_chain.sv | 89 ++++++++
 tb/tb_led_shift_chain.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared constants, event encoding and sizing helper for the LED shift chain.
package led_pkg;

  localparam int LED_CHIP_W  = 8;
  localparam int LED_N_CHIPS = 4;
  localparam int LED_PWM_W   = 4;

  // What a single SHCP edge does to the chain, built from {STCP, SHIFT_EN}.
  typedef enum logic [1:0] {
    EV_IDLE  = 2'b00,
    EV_SHIFT = 2'b01,
    EV_LATCH = 2'b10,
    EV_BOTH  = 2'b11
  } led_event_e;

  // Counter width able to hold 0..tot-1, never narrower than one bit.
  function automatic int led_cnt_w(input int tot);
    return (tot < 2) ? 1 : $clog2(tot);
  endfunction

endpackage

// File: rtl/led_pwm_gen.sv
// Global brightness PWM: free-running counter, period-aligned duty capture
// and a registered enable used to gate the whole panel.
module led_pwm_gen
  import led_pkg::*;
#(
  parameter int PWM_W = LED_PWM_W
) (
  input  logic             SHCP,
  input  logic             rst,
  input  logic [PWM_W-1:0] brightness,
  output logic             pwm_on
);

  logic [PWM_W-1:0] pwm_cnt;
  logic [PWM_W-1:0] pwm_cnt_next;
  logic [PWM_W-1:0] brightness_q;
  logic [PWM_W-1:0] brightness_next;
  logic             pwm_on_next;

  // Next counter value, next captured duty (only taken at the period
  // boundary) and the enable as it must look once both have advanced.
  always_comb begin
    pwm_cnt_next    = pwm_cnt + PWM_W'(1);
    brightness_next = (pwm_cnt == '1) ? brightness : brightness_q;
    pwm_on_next     = (brightness_next == '1) || (pwm_cnt_next < brightness_next);
  end

  // Counter, captured duty and enable; reset starts at full brightness.
  always_ff @(posedge SHCP or negedge rst) begin
    if (!rst) begin
      pwm_cnt      <= '0;
      brightness_q <= '1;
      pwm_on       <= 1'b1;
    end else begin
      pwm_cnt      <= pwm_cnt_next;
      brightness_q <= brightness_next;
      pwm_on       <= pwm_on_next;
    end
  end

endmodule

// File: rtl/led_shift_chain.sv
// Cascade of N_CHIPS 595-style stages: serial shift register, output latch,
// frame bit counter with completion pulse, cascade output and PWM blanking.
module led_shift_chain
  import led_pkg::*;
#(
  parameter int N_CHIPS = LED_N_CHIPS,
  parameter int CHIP_W  = LED_CHIP_W,
  parameter int PWM_W   = LED_PWM_W
) (
  input  logic                                   SHCP,
  input  logic                                   rst,
  input  logic                                   DS,
  input  logic                                   SHIFT_EN,
  input  logic                                   STCP,
  input  logic                                   OE,
  input  logic [PWM_W-1:0]                       brightness,
  output logic [N_CHIPS*CHIP_W-1:0]              out,
  output logic                                   Q7S,
  output logic [led_cnt_w(N_CHIPS*CHIP_W)-1:0]   bit_cnt,
  output logic                                   frame_full
);

  localparam int TOT   = N_CHIPS * CHIP_W;
  localparam int CNT_W = led_cnt_w(TOT);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(TOT - 1);

  logic [TOT-1:0] shift_reg;
  logic [TOT-1:0] latch_reg;
  logic           pwm_on;
  led_event_e     ev;

  led_pwm_gen #(
    .PWM_W(PWM_W)
  ) u_pwm (
    .SHCP      (SHCP),
    .rst       (rst),
    .brightness(brightness),
    .pwm_on    (pwm_on)
  );

  // Classify the current edge from the two strobes.
  always_comb begin
    ev = led_event_e'({STCP, SHIFT_EN});
  end

  // Shift register and latch; the latch always sees the pre-shift contents
  // because both registers update on the same edge.
  always_ff @(posedge SHCP or negedge rst) begin
    if (!rst) begin
      shift_reg <= '0;
      latch_reg <= '0;
    end else begin
      if (STCP) begin
        latch_reg <= shift_reg;
      end
      if (SHIFT_EN) begin
        shift_reg <= TOT'({shift_reg, DS});
      end
    end
  end

  // Frame bit counter; a latch restarts the frame (counting the bit shifted
  // on the same edge), and only a wrap caused by shifting raises frame_full.
  always_ff @(posedge SHCP or negedge rst) begin
    if (!rst) begin
      bit_cnt    <= '0;
      frame_full <= 1'b0;
    end else begin
      frame_full <= 1'b0;
      case (ev)
        EV_SHIFT: begin
          if (bit_cnt == LAST_BIT) begin
            bit_cnt    <= '0;
            frame_full <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        EV_LATCH: bit_cnt <= '0;
        EV_BOTH:  bit_cnt <= CNT_W'(1);
        default:  bit_cnt <= bit_cnt;
      endcase
    end
  end

  assign Q7S = shift_reg[TOT-1];
  assign out = (!OE && pwm_on) ? latch_reg : '0;

endmodule

// File: tb/tb_led_shift_chain.sv
// Randomised and directed bench for led_shift_chain: a default 4x8/PWM4
// instance and a 2x8/PWM2 instance share stimulus and are compared every
// cycle against a bit-level reference model of the panel.
module tb_led_shift_chain;

  logic        SHCP;
  logic        rst;
  logic        DS;
  logic        SHIFT_EN;
  logic        STCP;
  logic        OE;
  logic [3:0]  brightness;
  logic [1:0]  brightness_b;

  logic [31:0] out_a;
  logic        q7s_a;
  logic [4:0]  bit_cnt_a;
  logic        frame_full_a;

  logic [15:0] out_b;
  logic        q7s_b;
  logic [3:0]  bit_cnt_b;
  logic        frame_full_b;

  int total_checks = 0;
  int bad_checks   = 0;

  // reference model state
  logic [63:0] m_sr_a, m_latch_a, m_sr_b, m_latch_b;
  int          m_cnt_a, m_cnt_b;
  bit          m_ff_a, m_ff_b;
  int          m_edges;
  int          m_bq_a, m_bq_b;

  assign brightness_b = brightness[1:0];

  led_shift_chain dut_a (
    .SHCP      (SHCP),
    .rst       (rst),
    .DS        (DS),
    .SHIFT_EN  (SHIFT_EN),
    .STCP      (STCP),
    .OE        (OE),
    .brightness(brightness),
    .out       (out_a),
    .Q7S       (q7s_a),
    .bit_cnt   (bit_cnt_a),
    .frame_full(frame_full_a)
  );

  led_shift_chain #(
    .N_CHIPS(2),
    .CHIP_W (8),
    .PWM_W  (2)
  ) dut_b (
    .SHCP      (SHCP),
    .rst       (rst),
    .DS        (DS),
    .SHIFT_EN  (SHIFT_EN),
    .STCP      (STCP),
    .OE        (OE),
    .brightness(brightness_b),
    .out       (out_b),
    .Q7S       (q7s_b),
    .bit_cnt   (bit_cnt_b),
    .frame_full(frame_full_b)
  );

  initial SHCP = 1'b0;
  always #5 SHCP = ~SHCP;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total_checks++;
    if (observed !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_sr_a = '0; m_latch_a = '0; m_cnt_a = 0; m_ff_a = 0;
    m_sr_b = '0; m_latch_b = '0; m_cnt_b = 0; m_ff_b = 0;
    m_edges = 0;
    m_bq_a = 15;
    m_bq_b = 3;
  endtask

  // One chain of tot bits at one edge: latch sees old contents, a latch
  // restarts the frame count, a shift-only frame completion pulses.
  task automatic chain_edge(input int tot, input logic ds, input logic sh, input logic st,
                            inout logic [63:0] sr, inout logic [63:0] latch,
                            inout int cnt, inout bit ff);
    logic [63:0] mask;
    mask = (64'd1 << tot) - 64'd1;
    if (st) latch = sr;
    if (sh) sr = ((sr << 1) | 64'(ds)) & mask;
    ff = 0;
    if (st) cnt = sh ? 1 : 0;
    else if (sh) begin
      cnt = cnt + 1;
      if (cnt == tot) begin
        cnt = 0;
        ff = 1;
      end
    end
  endtask

  task automatic model_edge(input logic ds, input logic sh, input logic st);
    if (m_edges % 16 == 15) m_bq_a = int'(brightness);
    if (m_edges % 4 == 3)   m_bq_b = int'(brightness[1:0]);
    m_edges++;
    chain_edge(32, ds, sh, st, m_sr_a, m_latch_a, m_cnt_a, m_ff_a);
    chain_edge(16, ds, sh, st, m_sr_b, m_latch_b, m_cnt_b, m_ff_b);
  endtask

  function automatic logic [63:0] exp_out_a();
    bit on;
    on = (m_bq_a == 15) || ((m_edges % 16) < m_bq_a);
    return (!OE && on) ? m_latch_a : 64'd0;
  endfunction

  function automatic logic [63:0] exp_out_b();
    bit on;
    on = (m_bq_b == 3) || ((m_edges % 4) < m_bq_b);
    return (!OE && on) ? m_latch_b : 64'd0;
  endfunction

  task automatic compare_all();
    checkOutput("a.out",        64'(out_a),        exp_out_a());
    checkOutput("a.Q7S",        64'(q7s_a),        64'(m_sr_a[31]));
    checkOutput("a.bit_cnt",    64'(bit_cnt_a),    64'(m_cnt_a));
    checkOutput("a.frame_full", 64'(frame_full_a), 64'(m_ff_a));
    checkOutput("b.out",        64'(out_b),        exp_out_b());
    checkOutput("b.Q7S",        64'(q7s_b),        64'(m_sr_b[15]));
    checkOutput("b.bit_cnt",    64'(bit_cnt_b),    64'(m_cnt_b));
    checkOutput("b.frame_full", 64'(frame_full_b), 64'(m_ff_b));
  endtask

  task automatic applyStimulus(input logic ds, input logic sh, input logic st);
    DS = ds; SHIFT_EN = sh; STCP = st;
    @(posedge SHCP);
    model_edge(ds, sh, st);
    #1;
    compare_all();
  endtask

  task automatic shift_word(input logic [31:0] w, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) applyStimulus(w[i], 1'b1, 1'b0);
  endtask

  task automatic check_reset_zero(input string tag);
    checkOutput({tag, ".out_a"},   64'(out_a),     64'd0);
    checkOutput({tag, ".q7s_a"},   64'(q7s_a),     64'd0);
    checkOutput({tag, ".bitcnt_a"}, 64'(bit_cnt_a), 64'd0);
    checkOutput({tag, ".out_b"},   64'(out_b),     64'd0);
  endtask

  initial begin
    int on_count;
    rst = 1'b0; DS = 1'b1; SHIFT_EN = 1'b1; STCP = 1'b0; OE = 1'b0; brightness = 4'hF;
    model_reset();

    // reset held with active strobes
    for (int i = 0; i < 6; i++) begin
      STCP = i[0];
      @(posedge SHCP);
      #1;
      check_reset_zero("rst_hold");
    end
    rst = 1'b1;
    STCP = 1'b0;

    // full frame of ones, then latch
    for (int i = 0; i < 32; i++) applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("ones_latched", 64'(out_a), 64'hFFFF_FFFF);

    // ordering and cascade
    shift_word(32'hDEADBEEF, 32);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("deadbeef_a", 64'(out_a), 64'hDEAD_BEEF);
    checkOutput("beef_b",     64'(out_b), 64'hBEEF);
    shift_word(32'h0, 32);

    // narrow chain word
    shift_word(32'h0000_A55A, 16);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("a55a_b", 64'(out_b), 64'hA55A);

    // async reset mid-frame, then simultaneous shift+latch
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, i == 9);
    rst = 1'b0;
    #1;
    check_reset_zero("rst_async");
    model_reset();
    #3;
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("both_latch",  64'(out_a),     64'h1);
    checkOutput("both_cnt",    64'(bit_cnt_a), 64'd1);
    checkOutput("both_ff",     64'(frame_full_a), 64'd0);
    shift_word(32'hDEADBEEF, 32);
    applyStimulus(1'b0, 1'b0, 1'b1);

    // combinational blanking
    OE = 1'b1;
    #1;
    checkOutput("oe_blank", 64'(out_a), 64'd0);
    OE = 1'b0;
    #1;
    checkOutput("oe_restore", 64'(out_a), 64'hDEAD_BEEF);

    // duty 4/16, then 0/16
    brightness = 4'd4;
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    on_count = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      if (out_a != 0) on_count++;
    end
    checkOutput("duty4", 64'(on_count), 64'd4);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    brightness = 4'd12;
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    brightness = 4'd0;
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    on_count = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      if (out_a != 0) on_count++;
    end
    checkOutput("duty0", 64'(on_count), 64'd0);

    // randomised traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 24) == 0) brightness = 4'($urandom_range(0, 15));
      OE = ($urandom_range(0, 9) == 0);
      applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7),
                    ($urandom_range(0, 19) == 0));
    end

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
